// File: rtl/fp16_somador_sequencial.sv
// Multi-cycle binary16 adder/subtractor: one alignment or normalisation shift per cycle.
// Optional macro FP16_ARREDONDA_PAR_EN enables round-to-nearest-even; otherwise truncates.
module fp16_somador_sequencial #(
    parameter int LARG_ALINHA = 14
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inicio,
    input  logic        operacao,
    input  logic [15:0] entrada_a,
    input  logic [15:0] entrada_b,
    output logic [15:0] resultado,
    output logic        pronto,
    output logic        ocupado,
    output logic        overflow,
    output logic        underflow,
    output logic        invalido
);

    typedef enum logic [2:0] {
        OCIOSO, PREPARA, ALINHA, SOMA, NORMALIZA, ARREDONDA, FIM
    } estado_t;

    localparam logic [4:0] LIMITE = 5'(LARG_ALINHA);

    estado_t estado, estado_prox;

    logic [15:0] op_a, op_b;
    logic        op_sub;
    logic [13:0] sig_g, sig_p;
    logic        sin_g, sin_p;
    logic [14:0] sig;
    logic [5:0]  exp_cur;
    logic [4:0]  cont;
    logic [15:0] res_i;
    logic        ovf_i, unf_i, inv_i;

    logic [4:0]  exp_a, exp_b, exp_g, exp_p, dif;
    logic [9:0]  man_a, man_b, man_g, man_p;
    logic        sin_a, sin_b, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, a_maior;
    logic        especial, inv_especial;
    logic [15:0] res_especial;
    logic [14:0] soma_calc;
    logic        incr, carry_arr, ovf_arr;
    logic [11:0] man_arr;
    logic [5:0]  exp_arr;
    logic [15:0] res_arr;

    // Unpack, magnitude ordering and special-case resolution (used in PREPARA)
    always_comb begin
        exp_a  = op_a[14:10];
        exp_b  = op_b[14:10];
        man_a  = op_a[9:0];
        man_b  = op_b[9:0];
        sin_a  = op_a[15];
        sin_b  = op_b[15] ^ op_sub;
        nan_a  = (exp_a == 5'h1F) && (man_a != 10'd0);
        nan_b  = (exp_b == 5'h1F) && (man_b != 10'd0);
        inf_a  = (exp_a == 5'h1F) && (man_a == 10'd0);
        inf_b  = (exp_b == 5'h1F) && (man_b == 10'd0);
        zero_a = (exp_a == 5'd0);
        zero_b = (exp_b == 5'd0);
        a_maior = {exp_a, man_a} >= {exp_b, man_b};
        exp_g  = a_maior ? exp_a : exp_b;
        exp_p  = a_maior ? exp_b : exp_a;
        man_g  = a_maior ? man_a : man_b;
        man_p  = a_maior ? man_b : man_a;
        dif    = exp_g - exp_p;

        especial     = 1'b1;
        inv_especial = 1'b0;
        res_especial = 16'h0000;
        if (nan_a || nan_b || (inf_a && inf_b && (sin_a != sin_b))) begin
            res_especial = 16'h7E00;
            inv_especial = 1'b1;
        end else if (inf_a) begin
            res_especial = {sin_a, 5'h1F, 10'd0};
        end else if (inf_b) begin
            res_especial = {sin_b, 5'h1F, 10'd0};
        end else if (zero_a && zero_b) begin
            res_especial = {sin_a & sin_b, 15'd0};
        end else if (zero_a) begin
            res_especial = {sin_b, op_b[14:0]};
        end else if (zero_b) begin
            res_especial = {sin_a, op_a[14:0]};
        end else begin
            especial = 1'b0;
        end
    end

    // Significand add/subtract and rounding arithmetic
    always_comb begin
        soma_calc = (sin_g != sin_p) ? ({1'b0, sig_g} - {1'b0, sig_p})
                                     : ({1'b0, sig_g} + {1'b0, sig_p});
`ifdef FP16_ARREDONDA_PAR_EN
        incr = sig[2] & (sig[1] | sig[0] | sig[3]);
`else
        incr = 1'b0;
`endif
        man_arr   = {1'b0, sig[13:3]} + {11'd0, incr};
        carry_arr = man_arr[11];
        exp_arr   = exp_cur + {5'd0, carry_arr};
        ovf_arr   = exp_arr >= 6'd31;
        if (ovf_arr)
            res_arr = {sin_g, 5'h1F, 10'd0};
        else
            res_arr = {sin_g, exp_arr[4:0], carry_arr ? man_arr[10:1] : man_arr[9:0]};
    end

    always_ff @(posedge clock) begin
        if (reset)
            estado <= OCIOSO;
        else
            estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:    if (inicio && !ocupado) estado_prox = PREPARA;
            PREPARA:   estado_prox = especial ? FIM : ((dif == 5'd0) ? SOMA : ALINHA);
            ALINHA:    if (cont == 5'd1) estado_prox = SOMA;
            SOMA: begin
                if (soma_calc == 15'd0)
                    estado_prox = FIM;
                else if (soma_calc[14] || !soma_calc[13])
                    estado_prox = NORMALIZA;
                else
                    estado_prox = ARREDONDA;
            end
            NORMALIZA: begin
                if (sig[14] || sig[12])
                    estado_prox = ARREDONDA;
                else if (exp_cur == 6'd1)
                    estado_prox = FIM;
            end
            ARREDONDA: estado_prox = FIM;
            FIM:       estado_prox = OCIOSO;
            default:   estado_prox = OCIOSO;
        endcase
    end

    // Datapath registers; outputs are only updated when leaving FIM
    always_ff @(posedge clock) begin
        if (reset) begin
            op_a <= '0; op_b <= '0; op_sub <= 1'b0;
            sig_g <= '0; sig_p <= '0; sin_g <= 1'b0; sin_p <= 1'b0;
            sig <= '0; exp_cur <= '0; cont <= '0;
            res_i <= '0; ovf_i <= 1'b0; unf_i <= 1'b0; inv_i <= 1'b0;
            resultado <= '0; pronto <= 1'b0; ocupado <= 1'b0;
            overflow <= 1'b0; underflow <= 1'b0; invalido <= 1'b0;
        end else begin
            pronto  <= (estado == FIM);
            ocupado <= (estado != OCIOSO);
            case (estado)
                OCIOSO: begin
                    if (inicio && !ocupado) begin
                        op_a      <= entrada_a;
                        op_b      <= entrada_b;
                        op_sub    <= operacao;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        invalido  <= 1'b0;
                    end
                end
                PREPARA: begin
                    res_i   <= res_especial;
                    inv_i   <= inv_especial;
                    ovf_i   <= 1'b0;
                    unf_i   <= 1'b0;
                    sig_g   <= {1'b1, man_g, 3'b000};
                    sig_p   <= {1'b1, man_p, 3'b000};
                    sin_g   <= a_maior ? sin_a : sin_b;
                    sin_p   <= a_maior ? sin_b : sin_a;
                    exp_cur <= {1'b0, exp_g};
                    cont    <= (dif > LIMITE) ? LIMITE : dif;
                end
                ALINHA: begin
                    sig_p <= {1'b0, sig_p[13:2], sig_p[1] | sig_p[0]};
                    cont  <= cont - 5'd1;
                end
                SOMA: begin
                    sig <= soma_calc;
                    if (soma_calc == 15'd0)
                        res_i <= 16'h0000;
                end
                NORMALIZA: begin
                    if (sig[14]) begin
                        sig     <= {1'b0, sig[14:2], sig[1] | sig[0]};
                        exp_cur <= exp_cur + 6'd1;
                    end else if (exp_cur == 6'd1) begin
                        res_i <= {sin_g, 15'd0};
                        unf_i <= 1'b1;
                    end else begin
                        sig     <= {sig[13:0], 1'b0};
                        exp_cur <= exp_cur - 6'd1;
                    end
                end
                ARREDONDA: begin
                    res_i <= res_arr;
                    ovf_i <= ovf_arr;
                end
                FIM: begin
                    resultado <= res_i;
                    overflow  <= ovf_i;
                    underflow <= unf_i;
                    invalido  <= inv_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_somador_sequencial.sv
// Directed-vector bench for fp16_somador_sequencial with hand-computed results and latencies.
module tb_fp16_somador_sequencial;

    logic        clock = 1'b0;
    logic        reset;
    logic        inicio;
    logic        operacao;
    logic [15:0] entrada_a, entrada_b;
    logic [15:0] resultado;
    logic        pronto, ocupado, overflow, underflow, invalido;

    int erros  = 0;
    int checks = 0;

`ifdef FP16_ARREDONDA_PAR_EN
    localparam logic [15:0] ESP_EMPATE = 16'h3C02;
`else
    localparam logic [15:0] ESP_EMPATE = 16'h3C01;
`endif

    fp16_somador_sequencial dut (
        .clock(clock), .reset(reset), .inicio(inicio), .operacao(operacao),
        .entrada_a(entrada_a), .entrada_b(entrada_b), .resultado(resultado),
        .pronto(pronto), .ocupado(ocupado), .overflow(overflow),
        .underflow(underflow), .invalido(invalido)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, esp);
        end
    endtask

    // Launches one operation, waits (bounded) for pronto and checks result, flags and timing
    task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input logic op, input logic [15:0] res_esp,
                                 input logic [2:0] flags_esp, input int lat_esp);
        int lat  = 0;
        int ocup = 0;
        @(negedge clock);
        entrada_a = a; entrada_b = b; operacao = op; inicio = 1'b1;
        @(posedge clock);
        #1 inicio = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (ocupado) ocup++;
            if (pronto) begin
                lat = k;
                break;
            end
        end
        checkOutput($sformatf("%s latency", tag), lat, lat_esp);
        checkOutput($sformatf("%s ocupado cycles", tag), ocup, lat_esp);
        checkOutput($sformatf("%s resultado", tag), resultado, res_esp);
        checkOutput($sformatf("%s flags", tag), {overflow, underflow, invalido}, flags_esp);
        @(posedge clock);
        #1;
        checkOutput($sformatf("%s idle after", tag), {pronto, ocupado}, 2'b00);
    endtask

    initial begin
        int prontos;
        reset = 1'b1; inicio = 1'b0; operacao = 1'b0;
        entrada_a = 16'h0000; entrada_b = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset state", {resultado, pronto, ocupado, overflow, underflow, invalido}, 21'd0);
        reset = 1'b0;

        applyStimulus("1+1",        16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000, 5);
        applyStimulus("3-1",        16'h4200, 16'h3C00, 1'b1, 16'h4000, 3'b000, 5);
        applyStimulus("1-1",        16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000, 3);
        applyStimulus("max+max",    16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b100, 5);
        applyStimulus("inf-inf",    16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b001, 2);
        applyStimulus("tie",        16'h3C01, 16'h1000, 1'b0, ESP_EMPATE, 3'b000, 15);
        applyStimulus("denorm",     16'h3C00, 16'h0001, 1'b0, 16'h3C00, 3'b000, 2);
        applyStimulus("-0+-0",      16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000, 2);
        applyStimulus("underflow",  16'h0401, 16'h0400, 1'b1, 16'h0000, 3'b010, 4);
        applyStimulus("1.5-1",      16'h3E00, 16'h3C00, 1'b1, 16'h3800, 3'b000, 5);
        applyStimulus("1-2 swap",   16'h3C00, 16'h4000, 1'b1, 16'hBC00, 3'b000, 6);
        applyStimulus("align cap",  16'h7000, 16'h0400, 1'b0, 16'h7000, 3'b000, 18);
        applyStimulus("nan",        16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 3'b001, 2);
        applyStimulus("1-inf",      16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 3'b000, 2);
        applyStimulus("0-1",        16'h0000, 16'h3C00, 1'b1, 16'hBC00, 3'b000, 2);

        // A second inicio at edge 2 of a busy operation must not start anything
        @(negedge clock);
        entrada_a = 16'h3C00; entrada_b = 16'h3C00; operacao = 1'b0; inicio = 1'b1;
        @(posedge clock);
        #1 inicio = 1'b0;
        @(posedge clock);
        #1 begin
            entrada_a = 16'h7BFF; entrada_b = 16'h7BFF; inicio = 1'b1;
        end
        @(posedge clock);
        #1 inicio = 1'b0;
        prontos = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (pronto) begin
                prontos++;
                checkOutput("ignored inicio resultado", resultado, 16'h4000);
            end
        end
        checkOutput("ignored inicio pronto count", prontos, 1);

        // Reset at edge 3 aborts a long operation
        @(negedge clock);
        entrada_a = 16'h3C01; entrada_b = 16'h1000; operacao = 1'b0; inicio = 1'b1;
        @(posedge clock);
        #1 inicio = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        checkOutput("abort outputs", {resultado, pronto, ocupado, overflow, underflow, invalido}, 21'd0);
        prontos = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (pronto) prontos++;
        end
        checkOutput("abort no pronto", prontos, 0);
        applyStimulus("after reset", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000, 5);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
